ni_rdbk: RTL and testbench
==========================

// Module: ni_rdbk
// PURPOSE
//  Read-back responder for the NI 6501 mux address/data port: the return path to the write-side decoder.
//  On a read command (SR, status, HT low/mid/high) it snapshots the source register,
//  waits out a bus turnaround, then drives the byte to the NI host until module select drops.
//  Sits beside the write decoder under hemt_top; its dout/dout_oe feed the top-level addr pad tristate.
// PARAMETERS
//  TURN_CYC  4      clk cycles spent in TURN before driving; legal range 1..255
//  TIMEOUT   50000  max clk cycles in DRIVE before forced release; legal range 2..65535
// PORTS
//  clk       in   1   master fpga clk; all logic on posedge
//  rst_n     in   1   reset, asynchronous, active-low
//  mod_sel   in   1   NI module select, async (NI domain)
//  ale       in   1   NI address latch enable, async (NI domain)
//  cmd_vld   in   1   1-cycle pulse from write decoder: new command word latched
//  cmd       in   6   command code (addr[7:2] of command byte)
//  sr_reg    in   8   I2C status register
//  stat_reg  in   8   board status register
//  ht_cnt    in   20  HT counter, live
//  sw_in     in   1   switch input, reported with HT[19:16]
//  dout      out  8   read data to pad
//  dout_oe   out  1   pad output enable, active high
//  busy      out  1   state != IDLE
//  rd_err    out  1   1-cycle pulse on DRIVE timeout
// BEHAVIOUR
//  - mod_sel and ale each pass through 2-flop synchronizers -> mod_sel_s, ale_s; reset value 0.
//  - Reset (async): state=IDLE; dout=0, dout_oe=0, busy=0, rd_err=0, rd_buf=0, snap_vld=0.
//    Reset mid-operation drops dout_oe immediately; no glitch to 1.
//  - FSM states are IDLE, LATCH, TURN, DRIVE, RELEASE. All outputs are registered.
//  - IDLE: cmd_vld & cmd in {11,12,13,14,15} -> LATCH. Other codes, and cmd_vld outside IDLE, are ignored.
//  - LATCH (1 cycle): load rd_buf as follows:
//      11: sr_reg.  12: stat_reg.
//      13: ht_cnt[7:0]; also snapshot {sw_in, ht_cnt[19:8]} into ht_snap and set snap_vld.
//      14: snap_vld ? ht_snap[15:8] : ht_cnt[15:8].
//      15: {3'b000, sw, ht[19:16]}, taken from the snapshot if snap_vld else live; clears snap_vld.
//    Load turn counter with TURN_CYC-1; go to TURN.
//  - TURN: if mod_sel_s==0, abort to IDLE (never drive).
//    Otherwise go to DRIVE when the counter is 0 and ale_s==0; else decrement, saturating at 0.
//  - DRIVE: dout=rd_buf and dout_oe=1, both set on the entry edge.
//    Timer counts cycles in DRIVE.
//    mod_sel_s==0 -> RELEASE.
//    Else, when timer reaches TIMEOUT-1 -> RELEASE and pulse rd_err.
//    If both occur in the same cycle, release is normal and rd_err stays 0.
//  - RELEASE (1 cycle): dout_oe=0 and dout=0 on the entry edge; then -> IDLE.
//  - Latency: cmd_vld sampled at edge N -> dout_oe=1 at edge N+2+TURN_CYC,
//    given mod_sel_s=1 and ale_s=0 throughout.
//  - mod_sel falling -> dout_oe low within 3 clk edges (2 sync + 1 FSM).
//  - Width rules: turn counter 8 b, timeout timer 16 b; neither wraps.
// STRUCTURE
//  - Command codes live as `NI_CMD_SR..`NI_CMD_HT3 (11..15) in include/defines.v,
//    shared with the write decoder. Encode states as local parameters.
//  - Sub-module ni_sync2: 2-flop synchronizer with async active-low reset, instantiated for mod_sel and ale.
// TESTING
//  1. Reset, mod_sel=1, ale=0, sr_reg=8'hA5; pulse cmd_vld with cmd=11.
//     -> dout_oe rises exactly 6 edges later (TURN_CYC=4) with dout=8'hA5.
//     Drop mod_sel -> dout_oe=0 within 3 edges, busy=0 one edge later.
//  2. ht_cnt=20'hB3C5D, sw_in=1; read cmd13 (expect 8'h5D); set ht_cnt=20'h00000;
//     read cmd14 (expect 8'h3C), then cmd15 (expect 8'h1B).
//     A fourth read with cmd15 returns live data: 8'h10.
//  3. Hold ale=1 through TURN -> no drive. Drop ale -> DRIVE two synchronizer edges later.
//     Drop mod_sel during TURN instead -> IDLE, dout_oe never asserts.
//  4. Use TIMEOUT=20 and hold mod_sel high. -> dout_oe is high for exactly 20 cycles, rd_err pulses once,
//     then the block returns to IDLE.
//     Variant: mod_sel_s falls in the timeout cycle -> rd_err=0.
//  5. Send cmd=5 and cmd=0 -> stays IDLE. Send cmd_vld (cmd=12) while in DRIVE -> ignored, rd_buf unchanged.
//  6. Assert rst_n=0 asynchronously in DRIVE -> dout_oe=0 and dout=0 immediately, without a clk edge.
//     After release of reset: IDLE, snap_vld=0.

Source files
------------

// File: rtl/ni_rdbk_pkg.sv
// Shared types and command codes for the NI 6501 read-back responder.
// Command codes match the write-side decoder (addr[7:2] of the command byte).
package ni_rdbk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_TURN    = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [5:0] NI_CMD_SR   = 6'd11;
  localparam logic [5:0] NI_CMD_STAT = 6'd12;
  localparam logic [5:0] NI_CMD_HT1  = 6'd13;
  localparam logic [5:0] NI_CMD_HT2  = 6'd14;
  localparam logic [5:0] NI_CMD_HT3  = 6'd15;

  function automatic logic is_rd_cmd(input logic [5:0] i_code);
    return (i_code >= NI_CMD_SR) && (i_code <= NI_CMD_HT3);
  endfunction

endpackage

// File: rtl/ni_rdbk_if.sv
// NI host-side bus seen by the read-back responder: select/latch strobes,
// decoded command pulse, and the data/enable pair feeding the addr pad tristate.
interface ni_rdbk_if;
  logic       mod_sel;
  logic       ale;
  logic       cmd_vld;
  logic [5:0] cmd;
  logic [7:0] dout;
  logic       dout_oe;
  logic       busy;
  logic       rd_err;

  modport master (
    output mod_sel, ale, cmd_vld, cmd,
    input  dout, dout_oe, busy, rd_err
  );

  modport slave (
    input  mod_sel, ale, cmd_vld, cmd,
    output dout, dout_oe, busy, rd_err
  );
endinterface

// File: rtl/ni_sync2.sv
// Two-flop synchronizer for single-bit NI-domain strobes into clk.
module ni_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ni_rdbk.sv
// Read-back responder: snapshots the addressed source register, waits out the
// bus turnaround, then drives the byte to the NI host until module select drops.
module ni_rdbk
  import ni_rdbk_pkg::*;
#(
  parameter int unsigned TURN_CYC = 4,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ni_rdbk_if.slave    io_bus,
  input  logic [7:0]  i_sr_reg,
  input  logic [7:0]  i_stat_reg,
  input  logic [19:0] i_ht_cnt,
  input  logic        i_sw_in
);

  localparam logic [7:0]  TURN_LD = 8'(TURN_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic w_mod_sel_s;
  logic w_ale_s;

  ni_sync2 u_sync_mod_sel (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (io_bus.mod_sel),
    .o_q     (w_mod_sel_s)
  );

  ni_sync2 u_sync_ale (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (io_bus.ale),
    .o_q     (w_ale_s)
  );

  state_t      r_state;
  logic        r_cmd_vld;
  logic [5:0]  r_cmd;
  logic [5:0]  r_op;
  logic [7:0]  r_rd_buf;
  logic [19:8] r_ht_snap;
  logic        r_sw_snap;
  logic        r_snap_vld;
  logic [7:0]  r_turn;
  logic [15:0] r_timer;
  logic [7:0]  r_dout;
  logic        r_dout_oe;
  logic        r_busy;
  logic        r_rd_err;

  // Command pulse is registered on arrival so the FSM decodes from a flop,
  // not straight off the write decoder; this is the first latency cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd_vld  <= 1'b0;
      r_cmd      <= '0;
      r_op       <= '0;
      r_rd_buf   <= '0;
      r_ht_snap  <= '0;
      r_sw_snap  <= 1'b0;
      r_snap_vld <= 1'b0;
      r_turn     <= '0;
      r_timer    <= '0;
      r_dout     <= '0;
      r_dout_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_cmd_vld <= io_bus.cmd_vld;
      r_cmd     <= io_bus.cmd;
      r_rd_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_cmd_vld && is_rd_cmd(r_cmd)) begin
            r_op    <= r_cmd;
            r_state <= ST_LATCH;
            r_busy  <= 1'b1;
          end
        end
        ST_LATCH: begin
          case (r_op)
            NI_CMD_STAT: r_rd_buf <= i_stat_reg;
            NI_CMD_HT1: begin
              r_rd_buf   <= i_ht_cnt[7:0];
              r_ht_snap  <= i_ht_cnt[19:8];
              r_sw_snap  <= i_sw_in;
              r_snap_vld <= 1'b1;
            end
            NI_CMD_HT2: r_rd_buf <= r_snap_vld ? r_ht_snap[15:8] : i_ht_cnt[15:8];
            NI_CMD_HT3: begin
              r_rd_buf   <= r_snap_vld ? {3'b000, r_sw_snap, r_ht_snap[19:16]}
                                       : {3'b000, i_sw_in, i_ht_cnt[19:16]};
              r_snap_vld <= 1'b0;
            end
            default: r_rd_buf <= i_sr_reg;
          endcase
          r_turn  <= TURN_LD;
          r_state <= ST_TURN;
        end
        ST_TURN: begin
          if (!w_mod_sel_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if ((r_turn == 8'd0) && !w_ale_s) begin
            r_state   <= ST_DRIVE;
            r_dout    <= r_rd_buf;
            r_dout_oe <= 1'b1;
            r_timer   <= '0;
          end else if (r_turn != 8'd0) begin
            r_turn <= r_turn - 8'd1;
          end
        end
        ST_DRIVE: begin
          // A host release in the timeout cycle wins; no error in that case.
          if (!w_mod_sel_s) begin
            r_state   <= ST_RELEASE;
            r_dout    <= '0;
            r_dout_oe <= 1'b0;
          end else if (r_timer == TO_LAST) begin
            r_state   <= ST_RELEASE;
            r_dout    <= '0;
            r_dout_oe <= 1'b0;
            r_rd_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_dout    <= '0;
          r_dout_oe <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.dout    = r_dout;
  assign io_bus.dout_oe = r_dout_oe;
  assign io_bus.busy    = r_busy;
  assign io_bus.rd_err  = r_rd_err;

endmodule

// File: tb/tb_ni_rdbk.sv
// Directed bench for ni_rdbk: read latency, HT snapshot path, turnaround
// gating, DRIVE timeout, ignored commands and asynchronous reset.
module tb_ni_rdbk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sr_reg;
  logic [7:0]  stat_reg;
  logic [19:0] ht_cnt;
  logic        sw_in;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ni_rdbk_if bus ();

  ni_rdbk #(
    .TURN_CYC (4),
    .TIMEOUT  (20)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .io_bus     (bus),
    .i_sr_reg   (sr_reg),
    .i_stat_reg (stat_reg),
    .i_ht_cnt   (ht_cnt),
    .i_sw_in    (sw_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] c);
    bus.cmd     = c;
    bus.cmd_vld = 1'b1;
    tick();
    bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_drive(input string tag, input int exp_lat);
    int k = 0;
    while (!bus.dout_oe && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_qsize"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check({tag, "_dout"}, bus.dout, exp_q.pop_front());
  endtask

  task automatic release_bus(input string tag);
    int k = 0;
    bus.mod_sel = 1'b0;
    while (bus.dout_oe && k < 10) begin
      tick();
      k++;
    end
    check({tag, "_rel_edges_le3"}, (k <= 3), 1);
    check({tag, "_rel_dout"}, bus.dout, 8'h00);
    tick();
    check({tag, "_rel_busy"}, bus.busy, 1'b0);
    bus.mod_sel = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int n_hi;
    int n_rd;
    logic seen;

    rst_n       = 1'b0;
    bus.mod_sel = 1'b1;
    bus.ale     = 1'b0;
    bus.cmd_vld = 1'b0;
    bus.cmd     = '0;
    sr_reg      = 8'hA5;
    stat_reg    = 8'h00;
    ht_cnt      = '0;
    sw_in       = 1'b0;
    #2;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_oe", bus.dout_oe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rd_err", bus.rd_err, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // basic SR read, latency and release
    exp_q.push_back(8'hA5);
    issue(6'd11);
    wait_drive("t1_sr", 6);
    release_bus("t1");

    // HT snapshot path
    ht_cnt = 20'hB3C5D;
    sw_in  = 1'b1;
    exp_q.push_back(8'h5D);
    issue(6'd13);
    wait_drive("t2_ht1", 6);
    release_bus("t2a");
    ht_cnt = 20'h00000;
    exp_q.push_back(8'h3C);
    issue(6'd14);
    wait_drive("t2_ht2_snap", 6);
    release_bus("t2b");
    exp_q.push_back(8'h1B);
    issue(6'd15);
    wait_drive("t2_ht3_snap", 6);
    release_bus("t2c");
    exp_q.push_back(8'h10);
    issue(6'd15);
    wait_drive("t2_ht3_live", 6);
    release_bus("t2d");

    // ALE held through turnaround
    bus.ale = 1'b1;
    exp_q.push_back(8'hA5);
    issue(6'd11);
    repeat (12) tick();
    check("t3_ale_hold_oe", bus.dout_oe, 1'b0);
    check("t3_ale_hold_busy", bus.busy, 1'b1);
    bus.ale = 1'b0;
    tick();
    check("t3_ale_drop_e1_oe", bus.dout_oe, 1'b0);
    tick();
    tick();
    check("t3_ale_drop_e3_oe", bus.dout_oe, 1'b1);
    check("t3_qsize", exp_q.size(), 1);
    if (exp_q.size() > 0) check("t3_dout", bus.dout, exp_q.pop_front());
    release_bus("t3");

    // mod_sel drops during TURN
    issue(6'd12);
    tick();
    tick();
    bus.mod_sel = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.dout_oe) seen = 1'b1;
    end
    check("t3_abort_oe_seen", seen, 1'b0);
    check("t3_abort_busy", bus.busy, 1'b0);
    bus.mod_sel = 1'b1;
    repeat (3) tick();

    // DRIVE timeout
    exp_q.push_back(8'hA5);
    issue(6'd11);
    wait_drive("t4_to", 6);
    n_hi = 1;
    n_rd = 0;
    repeat (25) begin
      tick();
      if (bus.dout_oe) n_hi++;
      if (bus.rd_err) n_rd++;
    end
    check("t4_oe_cycles", n_hi, 20);
    check("t4_rd_err_pulses", n_rd, 1);
    check("t4_busy_after", bus.busy, 1'b0);

    // release lands in the timeout cycle
    exp_q.push_back(8'hA5);
    issue(6'd11);
    wait_drive("t4v_to", 6);
    n_hi = 1;
    n_rd = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus.dout_oe) n_hi++;
      if (bus.rd_err) n_rd++;
      if (k == 17) bus.mod_sel = 1'b0;
    end
    check("t4v_oe_cycles", n_hi, 20);
    check("t4v_rd_err_pulses", n_rd, 0);
    check("t4v_busy_after", bus.busy, 1'b0);
    bus.mod_sel = 1'b1;
    repeat (3) tick();

    // illegal codes ignored
    issue(6'd5);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.busy) seen = 1'b1;
    end
    check("t5_cmd5_busy", seen, 1'b0);
    issue(6'd0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.busy) seen = 1'b1;
    end
    check("t5_cmd0_busy", seen, 1'b0);

    // command during DRIVE ignored
    stat_reg = 8'h3E;
    exp_q.push_back(8'h3E);
    issue(6'd12);
    wait_drive("t5_stat", 6);
    stat_reg = 8'h77;
    issue(6'd12);
    repeat (6) tick();
    check("t5_drive_dout_kept", bus.dout, 8'h3E);
    check("t5_drive_oe_kept", bus.dout_oe, 1'b1);
    release_bus("t5");
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.busy) seen = 1'b1;
    end
    check("t5_no_replay_busy", seen, 1'b0);

    // asynchronous reset in DRIVE
    ht_cnt = 20'h12345;
    sw_in  = 1'b0;
    exp_q.push_back(8'h45);
    issue(6'd13);
    wait_drive("t6_ht1", 6);
    release_bus("t6a");
    exp_q.push_back(8'hA5);
    issue(6'd11);
    wait_drive("t6_sr", 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_oe", bus.dout_oe, 1'b0);
    check("t6_async_dout", bus.dout, 8'h00);
    check("t6_async_busy", bus.busy, 1'b0);
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_post_busy", bus.busy, 1'b0);
    check("t6_post_oe", bus.dout_oe, 1'b0);
    ht_cnt = 20'hABCDE;
    exp_q.push_back(8'hBC);
    issue(6'd14);
    wait_drive("t6_ht2_live", 6);
    release_bus("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
